// File: rtl/ex_wb_buffer.sv
// Two-entry execute-to-writeback result buffer with register-file write port.
// Define EX_WB_FWD_EN to compile in the decode-stage forwarding lookup.
module ex_wb_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush_i,
  output logic              wb_we_o,
  output logic [4:0]        wb_waddr_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  input  logic              wb_ready_i,
  input  logic [4:0]        raddr_i,
  output logic              fwd_valid_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [1:0]        count_o
);

  logic [4:0]        mem_addr [2];
  logic [DATA_W-1:0] mem_data [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic transfer;
  logic store;
  logic pop;

  assign ex_ready_o = (count < 2'd2);
  assign transfer   = ex_valid_i & ex_ready_o;
  // Transfers without a real destination are accepted but never reach the register file.
  assign store      = transfer & wreg_i & (wd_i != 5'd0);
  assign wb_we_o    = (count != 2'd0);
  assign pop        = wb_we_o & wb_ready_i;

  assign wb_waddr_o = wb_we_o ? mem_addr[rd_ptr] : 5'd0;
  assign wb_wdata_o = wb_we_o ? mem_data[rd_ptr] : '0;
  assign count_o    = count;

  // Control state: pointers and occupancy; flush overrides store and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (store) wr_ptr <= ~wr_ptr;
      if (pop)   rd_ptr <= ~rd_ptr;
      case ({store, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_addr[wr_ptr] <= wd_i;
      mem_data[wr_ptr] <= wdata_i;
    end
  end

`ifdef EX_WB_FWD_EN
  logic young;
  assign young = ~wr_ptr;

  always_comb begin
    fwd_valid_o = 1'b0;
    fwd_data_o  = '0;
    if (raddr_i != 5'd0) begin
      if ((count != 2'd0) && (mem_addr[young] == raddr_i)) begin
        fwd_valid_o = 1'b1;
        fwd_data_o  = mem_data[young];
      end else if ((count == 2'd2) && (mem_addr[rd_ptr] == raddr_i)) begin
        fwd_valid_o = 1'b1;
        fwd_data_o  = mem_data[rd_ptr];
      end
    end
  end
`else
  logic unused_raddr;
  assign unused_raddr = ^raddr_i;
  assign fwd_valid_o  = 1'b0;
  assign fwd_data_o   = '0;
`endif

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Scoreboard bench for ex_wb_buffer: stimulus queues expected writes, a monitor checks them.
module tb_ex_wb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        flush_i;
  logic        wb_we_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic        wb_ready_i;
  logic [4:0]  raddr_i;
  logic        fwd_valid_o;
  logic [31:0] fwd_data_o;
  logic [1:0]  count_o;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q [$];

  ex_wb_buffer dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .flush_i(flush_i),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .wb_ready_i(wb_ready_i),
    .raddr_i(raddr_i), .fwd_valid_o(fwd_valid_o), .fwd_data_o(fwd_data_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] wd, input logic we, input logic [31:0] d);
    ex_valid_i = v;
    wd_i       = wd;
    wreg_i     = we;
    wdata_i    = d;
  endtask

  // Drive a push that the bench knows will be stored, and record what must come out.
  task automatic push_store(input logic [4:0] wd, input logic [31:0] d);
    drive(1'b1, wd, 1'b1, d);
    exp_q.push_back({wd, d});
  endtask

  // Monitor: every register-file handshake must match the oldest queued expectation.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (rst && !flush_i && wb_we_o && wb_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {27'd0, wb_waddr_o, wb_wdata_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", {59'd0, wb_waddr_o}, {59'd0, e[36:32]});
          check("wb_data", {32'd0, wb_wdata_o}, {32'd0, e[31:0]});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    flush_i = 1'b0; wb_ready_i = 1'b0; raddr_i = 5'd0;
    #1 rst = 1'b0;
    #1;
    check("rst_count", {62'd0, count_o}, 64'd0);
    check("rst_ready", {63'd0, ex_ready_o}, 64'd1);
    check("rst_we", {63'd0, wb_we_o}, 64'd0);
    check("rst_waddr", {59'd0, wb_waddr_o}, 64'd0);
    check("rst_wdata", {32'd0, wb_wdata_o}, 64'd0);
    check("rst_fwd", {31'd0, fwd_valid_o, fwd_data_o}, 64'd0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // Single store with latency one.
    wb_ready_i = 1'b1;
    push_store(5'd5, 32'h12345678);
    cyc();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    check("single_we", {63'd0, wb_we_o}, 64'd1);
    check("single_addr", {59'd0, wb_waddr_o}, 64'd5);
    check("single_data", {32'd0, wb_wdata_o}, 64'h12345678);
    check("single_count", {62'd0, count_o}, 64'd1);
    cyc();
    check("single_drain", {62'd0, count_o}, 64'd0);
    check("single_we_off", {63'd0, wb_we_o}, 64'd0);

    // Fill and stall, third push refused, then in-order drain.
    wb_ready_i = 1'b0;
    push_store(5'd3, 32'h33);
    cyc();
    push_store(5'd4, 32'h44);
    cyc();
    check("fill_count", {62'd0, count_o}, 64'd2);
    check("fill_ready", {63'd0, ex_ready_o}, 64'd0);
    drive(1'b1, 5'd6, 1'b1, 32'h66);
    cyc();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    check("stall_count", {62'd0, count_o}, 64'd2);
    check("stall_head", {59'd0, wb_waddr_o}, 64'd3);
    wb_ready_i = 1'b1;
    cyc();
    check("drain1_count", {62'd0, count_o}, 64'd1);
    check("drain1_head", {59'd0, wb_waddr_o}, 64'd4);
    cyc();
    check("drain2_count", {62'd0, count_o}, 64'd0);

    // Dropped transfers: accepted but never stored.
    drive(1'b1, 5'd7, 1'b0, 32'h77);
    check("drop_ready", {63'd0, ex_ready_o}, 64'd1);
    cyc();
    drive(1'b1, 5'd0, 1'b1, 32'h99);
    cyc();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    check("drop_count", {62'd0, count_o}, 64'd0);
    check("drop_we", {63'd0, wb_we_o}, 64'd0);

    // Simultaneous store and pop keeps occupancy.
    wb_ready_i = 1'b0;
    push_store(5'd10, 32'hA0A0);
    cyc();
    wb_ready_i = 1'b1;
    push_store(5'd11, 32'hB1B1);
    cyc();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    check("sp_count", {62'd0, count_o}, 64'd1);
    check("sp_head", {32'd0, wb_wdata_o}, 64'hB1B1);
    cyc();
    check("sp_drain", {62'd0, count_o}, 64'd0);

    // Flush beats a same-cycle push.
    wb_ready_i = 1'b0;
    push_store(5'd12, 32'hC);
    cyc();
    check("pre_flush_count", {62'd0, count_o}, 64'd1);
    flush_i = 1'b1;
    drive(1'b1, 5'd13, 1'b1, 32'hD);
    exp_q.delete();
    cyc();
    flush_i = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    check("flush_count", {62'd0, count_o}, 64'd0);
    check("flush_we", {63'd0, wb_we_o}, 64'd0);
    check("flush_ready", {63'd0, ex_ready_o}, 64'd1);

    // Forwarding picks the youngest matching entry.
    push_store(5'd9, 32'hA);
    cyc();
    push_store(5'd9, 32'hB);
    cyc();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    raddr_i = 5'd9;
    #1;
`ifdef EX_WB_FWD_EN
    check("fwd_valid", {63'd0, fwd_valid_o}, 64'd1);
    check("fwd_data", {32'd0, fwd_data_o}, 64'hB);
`else
    check("fwd_tied_valid", {63'd0, fwd_valid_o}, 64'd0);
    check("fwd_tied_data", {32'd0, fwd_data_o}, 64'd0);
`endif
    raddr_i = 5'd0;
    #1;
    check("fwd_r0_valid", {63'd0, fwd_valid_o}, 64'd0);

    // Asynchronous reset between edges with a full buffer.
    check("pre_rst_count", {62'd0, count_o}, 64'd2);
    #1 rst = 1'b0;
    exp_q.delete();
    #1;
    check("arst_count", {62'd0, count_o}, 64'd0);
    check("arst_ready", {63'd0, ex_ready_o}, 64'd1);
    check("arst_we", {63'd0, wb_we_o}, 64'd0);
    check("arst_addr", {59'd0, wb_waddr_o}, 64'd0);
    check("arst_data", {32'd0, wb_wdata_o}, 64'd0);
    cyc();
    rst = 1'b1;
    wb_ready_i = 1'b1;
    cyc();
    check("post_rst_we", {63'd0, wb_we_o}, 64'd0);
    cyc();
    check("sb_empty", {32'd0, exp_q.size()}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_wb_buffer.md
EX_WB_BUFFER -- requirements
Module: ex_wb_buffer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port ex_valid_i, input, 1 bit: execute stage presents a result this cycle.
REQ-004 SHALL have port ex_ready_o, output, 1 bit: buffer accepts the presented result this cycle.
REQ-005 SHALL have port wd_i, input, 5 bits: destination register address from execute.
REQ-006 SHALL have port wreg_i, input, 1 bit: destination write enable from execute.
REQ-007 SHALL have port wdata_i, input, 32 bits: result data from execute.
REQ-008 SHALL have port flush_i, input, 1 bit: discard all buffered results.
REQ-009 SHALL have port wb_we_o, output, 1 bit: register-file write request.
REQ-010 SHALL have port wb_waddr_o, output, 5 bits: register-file write address.
REQ-011 SHALL have port wb_wdata_o, output, 32 bits: register-file write data.
REQ-012 SHALL have port wb_ready_i, input, 1 bit: register file takes the request this cycle.
REQ-013 SHALL have port raddr_i, input, 5 bits: decode-stage read address for forwarding lookup.
REQ-014 SHALL have port fwd_valid_o, output, 1 bit: buffered value exists for raddr_i.
REQ-015 SHALL have port fwd_data_o, output, 32 bits: forwarded value.
REQ-016 SHALL have port count_o, output, 2 bits: current occupancy, 0..2.

Function
REQ-017 SHALL hold a 2-entry FIFO of {waddr[4:0], wdata[31:0]} with read/write pointers and a 2-bit count.
REQ-018 SHALL drive ex_ready_o = 1 when count < 2, else 0; no combinational dependence on wb_ready_i.
REQ-019 SHALL treat a transfer as occurring on a rising edge where ex_valid_i = 1 and ex_ready_o = 1.
REQ-020 SHALL store a transfer only if wreg_i = 1 and wd_i != 0; other transfers are accepted and dropped.
REQ-021 SHALL drive wb_we_o = 1 whenever count != 0, with wb_waddr_o/wb_wdata_o from the head entry.
REQ-022 SHALL drive wb_waddr_o = 0 and wb_wdata_o = 0 when count = 0.
REQ-023 SHALL pop the head on a rising edge where wb_we_o = 1 and wb_ready_i = 1.
REQ-024 SHALL leave count unchanged on a simultaneous store and pop; the entry written at the tail is unaffected by the pop.
REQ-025 SHALL wrap both pointers modulo 2.
REQ-026 SHALL give ex_valid_i with ex_ready_o = 0 no effect; execute holds its data.
REQ-027 SHALL, on flush_i = 1, set count and both pointers to 0 on the next edge, overriding any same-cycle store and pop.
REQ-028 SHALL give a stored result a latency of 1 cycle: it becomes visible on wb_we_o on the cycle after acceptance when the buffer was empty.
REQ-029 SHALL drive count_o = count.

Reset
REQ-030 SHALL, while rst = 0, force count, pointers, wb_we_o, wb_waddr_o, wb_wdata_o, fwd_valid_o, fwd_data_o and count_o to 0, and ex_ready_o to 1.
REQ-031 SHALL take reset asserted mid-transfer to discard all entries; no partial write is issued after release.

Configuration
REQ-032 SHALL compile the forwarding lookup in when macro EX_WB_FWD_EN is defined.
REQ-033 SHALL, with EX_WB_FWD_EN defined, set fwd_valid_o = 1 when raddr_i != 0 and raddr_i matches a valid entry; fwd_data_o is then the data of the youngest matching entry, else 0.
REQ-034 SHALL, without EX_WB_FWD_EN, keep the forwarding ports and tie fwd_valid_o = 0 and fwd_data_o = 0.

Verification
REQ-035 SHALL cover single store: empty; push wd=5, wreg=1, data=0x12345678; wb_ready_i=1 -> next cycle we=1, addr=5, data=0x12345678; cycle after, count=0.
REQ-036 SHALL cover fill and stall: wb_ready_i=0; push addr 3 then addr 4 -> count=2, ex_ready_o=0; third push ignored; release wb_ready_i -> writes to 3 then 4, in order.
REQ-037 SHALL cover drop cases: push wreg=0 (wd=7) and wreg=1 with wd=0 -> both accepted, count stays 0, wb_we_o stays 0.
REQ-038 SHALL cover flush priority: count=1 with flush_i=1 and a valid push in the same cycle -> next cycle count=0 and wb_we_o=0.
REQ-039 SHALL cover forwarding (EX_WB_FWD_EN defined): entries addr 9=0xA, addr 9=0xB (younger); raddr_i=9 -> fwd_valid_o=1, fwd_data_o=0xB; raddr_i=0 -> fwd_valid_o=0.
REQ-040 SHALL cover asynchronous reset: count=2, drop rst to 0 between edges -> outputs 0 and ex_ready_o=1 immediately, without waiting for a clock edge.
